// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline controller: FSM states, valid-bit
// positions and performance-counter width.
package pipe_pkg;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_STALL    = 3'd1,
    ST_MEM_WAIT = 3'd2,
    ST_FLUSH    = 3'd3,
    ST_DRAIN    = 3'd4,
    ST_HALTED   = 3'd5
  } state_e;

  localparam int unsigned VLD_W   = 4;
  localparam int unsigned VLD_ID  = 0;
  localparam int unsigned VLD_EX  = 1;
  localparam int unsigned VLD_MEM = 2;
  localparam int unsigned VLD_WB  = 3;

  localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// sat_counter: up-counter with increment enable that sticks at all-ones.
module sat_counter
  import pipe_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall / flush / drain controller for a 5-stage in-order pipeline.
// Define PIPE_CTRL_PERF_EN to build the stall and redirect counters.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REDIRECT_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hazard_stall,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        halt_req,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic [3:0]  vld,
  output logic        halted,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
);

  localparam int unsigned FCNT_W = 2;

  state_e             state_q, state_d;
  logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
  logic [VLD_W-1:0]   vld_q, vld_d;
  logic               mem_wait, redirect, hazard, drain_empty;

  // Event decode in priority order: memory wait, redirect, hazard.
  always_comb begin
    mem_wait    = vld_q[VLD_MEM] & mem_req & ~mem_ready;
    redirect    = branch_taken & vld_q[VLD_EX] & ~mem_wait;
    hazard      = hazard_stall & vld_q[VLD_ID] & ~mem_wait & ~redirect;
    // A drain cycle shifts in a bubble, so the pipe is empty afterwards
    // exactly when the three younger stages hold nothing now.
    drain_empty = ~|vld_q[VLD_MEM:VLD_ID];
  end

  // Next state, flush counter and stage controls.
  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    state_d     = ST_RUN;
    fcnt_d      = '0;

    if (reset) begin
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (state_q == ST_HALTED) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
      state_d   = halt_req ? ST_HALTED : ST_RUN;
    end else if (mem_wait) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
      state_d   = ST_MEM_WAIT;
    end else if (redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_d     = (REDIRECT_LAT > 0) ? ST_FLUSH : ST_RUN;
      fcnt_d      = FCNT_W'(REDIRECT_LAT);
    end else if (state_q == ST_FLUSH) begin
      if_id_flush = 1'b1;
      if (fcnt_q > FCNT_W'(1)) begin
        state_d = ST_FLUSH;
        fcnt_d  = fcnt_q - FCNT_W'(1);
      end
    end else if (hazard) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
      state_d     = ST_STALL;
    end else if (halt_req || (state_q == ST_DRAIN)) begin
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
      if (!halt_req)        state_d = ST_RUN;
      else if (drain_empty) state_d = ST_HALTED;
      else                  state_d = ST_DRAIN;
    end
  end

  // Valid bits follow their stage register enables.
  always_comb begin
    vld_d = vld_q;
    if (if_id_en)  vld_d[VLD_ID]  = ~if_id_flush;
    if (id_ex_en)  vld_d[VLD_EX]  = vld_q[VLD_ID] & ~id_ex_flush;
    if (ex_mem_en) vld_d[VLD_MEM] = vld_q[VLD_EX];
    if (mem_wb_en) vld_d[VLD_WB]  = vld_q[VLD_MEM];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      fcnt_q  <= '0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      vld_q   <= vld_d;
    end
  end

  assign vld    = vld_q;
  assign halted = (state_q == ST_HALTED) & ~reset;

`ifdef PIPE_CTRL_PERF_EN
  logic stall_inc;
  assign stall_inc = (state_d == ST_STALL) || (state_d == ST_MEM_WAIT);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (stall_inc),
    .cnt_o (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (redirect),
    .cnt_o (flush_count)
  );
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table, randomized run
// against a pipeline-occupancy model, and a stall-counter saturation run.
module tb_pipe_ctrl;

  localparam int unsigned LAT = 2;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Control word {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush}
  localparam logic [6:0] C_RST   = 7'b0111111;
  localparam logic [6:0] C_RUN   = 7'b1111100;
  localparam logic [6:0] C_HZ    = 7'b0011101;
  localparam logic [6:0] C_WAIT  = 7'b0000000;
  localparam logic [6:0] C_REDIR = 7'b1111111;
  localparam logic [6:0] C_FLUSH = 7'b1111110;
  localparam logic [6:0] C_DRAIN = 7'b0111110;
  localparam logic [6:0] C_HALT  = 7'b0000000;

  // Inputs {hazard_stall, branch_taken, mem_req, mem_ready, halt_req, reset}
  localparam logic [5:0] I_IDLE  = 6'b000000;
  localparam logic [5:0] I_RST   = 6'b000001;
  localparam logic [5:0] I_HZ    = 6'b100000;
  localparam logic [5:0] I_MW    = 6'b001000;
  localparam logic [5:0] I_MR    = 6'b001100;
  localparam logic [5:0] I_BRHZ  = 6'b110000;
  localparam logic [5:0] I_HR    = 6'b000010;
  localparam logic [5:0] I_RSTMW = 6'b001001;

  logic clk = 1'b0;
  logic reset, hazard_stall, branch_taken, mem_req, mem_ready, halt_req;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush;
  logic [3:0]  vld;
  logic        halted;
  logic [15:0] stall_cycles, flush_count;

  always #5 clk = ~clk;

  pipe_ctrl #(.REDIRECT_LAT(LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .hazard_stall (hazard_stall),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .halt_req     (halt_req),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .id_ex_en     (id_ex_en),
    .ex_mem_en    (ex_mem_en),
    .mem_wb_en    (mem_wb_en),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .vld          (vld),
    .halted       (halted),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model: which stages hold an instruction, plus pending work.
  bit m_vld[4];
  int m_fl;
  bit m_drain;
  bit m_halt;
  int m_sc;
  int m_fc;

  typedef struct {
    logic [5:0]  in;
    logic [6:0]  ctl;
    logic [3:0]  vld;
    logic        halt;
    logic [15:0] sc;
    logic [15:0] fc;
  } vec_t;

  vec_t tbl[32];

  function automatic vec_t mk(input logic [5:0] in, input logic [6:0] ctl,
                              input logic [3:0] v, input logic h,
                              input logic [15:0] sc, input logic [15:0] fc);
    vec_t r;
    r.in = in; r.ctl = ctl; r.vld = v; r.halt = h; r.sc = sc; r.fc = fc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, compare against the model, then advance the model.
  task automatic tick(input logic [5:0] iv, output logic [6:0] a_ctl,
                      output logic [3:0] a_vld, output logic a_halt,
                      output logic [15:0] a_sc, output logic [15:0] a_fc);
    bit hz, br, mr, mrdy, hr, rst;
    bit pc, fif, fex, drain, stall, redir, any;
    bit en[4];
    bit nv[4];
    logic [6:0] e_ctl;
    logic [3:0] e_vld;
    {hz, br, mr, mrdy, hr, rst} = iv;
    {hazard_stall, branch_taken, mem_req, mem_ready, halt_req, reset} = iv;
    #2;
    a_ctl  = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush};
    a_vld  = vld;
    a_halt = halted;
    a_sc   = stall_cycles;
    a_fc   = flush_count;

    pc = 1'b1; fif = 1'b0; fex = 1'b0; drain = 1'b0; stall = 1'b0; redir = 1'b0;
    for (int i = 0; i < 4; i++) en[i] = 1'b1;
    if (rst) begin
      pc = 1'b0; fif = 1'b1; fex = 1'b1;
    end else if (m_halt) begin
      pc = 1'b0;
      for (int i = 0; i < 4; i++) en[i] = 1'b0;
    end else if (m_vld[2] && mr && !mrdy) begin
      pc = 1'b0;
      for (int i = 0; i < 4; i++) en[i] = 1'b0;
      stall = 1'b1; m_fl = 0; m_drain = 1'b0;
    end else if (br && m_vld[1]) begin
      fif = 1'b1; fex = 1'b1; redir = 1'b1; m_fl = int'(LAT); m_drain = 1'b0;
    end else if (m_fl > 0) begin
      fif = 1'b1; m_fl--;
    end else if (hz && m_vld[0]) begin
      pc = 1'b0; en[0] = 1'b0; fex = 1'b1; stall = 1'b1;
    end else if (hr || m_drain) begin
      pc = 1'b0; fif = 1'b1; drain = 1'b1;
    end

    e_ctl = {pc, en[0], en[1], en[2], en[3], fif, fex};
    e_vld = {m_vld[3], m_vld[2], m_vld[1], m_vld[0]};
    if (chk_en) begin
      chk("ctl", 32'(a_ctl), 32'(e_ctl));
      chk("vld", 32'(a_vld), 32'(e_vld));
      chk("halted", 32'(a_halt), 32'(m_halt & ~rst));
      chk("stall_cycles", 32'(a_sc), PERF ? 32'(m_sc) : 32'd0);
      chk("flush_count", 32'(a_fc), PERF ? 32'(m_fc) : 32'd0);
    end

    if (rst) begin
      for (int i = 0; i < 4; i++) m_vld[i] = 1'b0;
      m_fl = 0; m_drain = 1'b0; m_halt = 1'b0; m_sc = 0; m_fc = 0;
    end else if (m_halt) begin
      m_halt = hr;
    end else begin
      nv[0] = en[0] ? !fif : m_vld[0];
      nv[1] = en[1] ? (m_vld[0] && !fex) : m_vld[1];
      for (int i = 2; i < 4; i++) nv[i] = en[i] ? m_vld[i-1] : m_vld[i];
      m_vld = nv;
      if (drain) begin
        any = 1'b0;
        for (int i = 0; i < 4; i++) any |= m_vld[i];
        m_drain = hr && any;
        m_halt  = hr && !any;
      end
      if (stall && m_sc < 65535) m_sc++;
      if (redir && m_fc < 65535) m_fc++;
    end
    @(posedge clk);
    #1;
  endtask

  logic [6:0]  a_ctl;
  logic [3:0]  a_vld;
  logic        a_halt;
  logic [15:0] a_sc, a_fc;
  logic        hr_lvl;
  logic [5:0]  iv;

  initial begin
    // REQ-030 fill/hazard, REQ-031 mem wait, REQ-032 redirect, REQ-033 halt, REQ-034 reset
    tbl[0]  = mk(I_RST,   C_RST,   4'b0000, 1'b0, 16'd0, 16'd0);
    tbl[1]  = mk(I_IDLE,  C_RUN,   4'b0000, 1'b0, 16'd0, 16'd0);
    tbl[2]  = mk(I_IDLE,  C_RUN,   4'b0001, 1'b0, 16'd0, 16'd0);
    tbl[3]  = mk(I_IDLE,  C_RUN,   4'b0011, 1'b0, 16'd0, 16'd0);
    tbl[4]  = mk(I_IDLE,  C_RUN,   4'b0111, 1'b0, 16'd0, 16'd0);
    tbl[5]  = mk(I_HZ,    C_HZ,    4'b1111, 1'b0, 16'd0, 16'd0);
    tbl[6]  = mk(I_HZ,    C_HZ,    4'b1101, 1'b0, 16'd1, 16'd0);
    tbl[7]  = mk(I_IDLE,  C_RUN,   4'b1001, 1'b0, 16'd2, 16'd0);
    tbl[8]  = mk(I_IDLE,  C_RUN,   4'b0011, 1'b0, 16'd2, 16'd0);
    tbl[9]  = mk(I_MW,    C_WAIT,  4'b0111, 1'b0, 16'd2, 16'd0);
    tbl[10] = mk(I_MW,    C_WAIT,  4'b0111, 1'b0, 16'd3, 16'd0);
    tbl[11] = mk(I_MW,    C_WAIT,  4'b0111, 1'b0, 16'd4, 16'd0);
    tbl[12] = mk(I_MR,    C_RUN,   4'b0111, 1'b0, 16'd5, 16'd0);
    tbl[13] = mk(I_BRHZ,  C_REDIR, 4'b1111, 1'b0, 16'd5, 16'd0);
    tbl[14] = mk(I_IDLE,  C_FLUSH, 4'b1100, 1'b0, 16'd5, 16'd1);
    tbl[15] = mk(I_IDLE,  C_FLUSH, 4'b1000, 1'b0, 16'd5, 16'd1);
    tbl[16] = mk(I_IDLE,  C_RUN,   4'b0000, 1'b0, 16'd5, 16'd1);
    tbl[17] = mk(I_IDLE,  C_RUN,   4'b0001, 1'b0, 16'd5, 16'd1);
    tbl[18] = mk(I_IDLE,  C_RUN,   4'b0011, 1'b0, 16'd5, 16'd1);
    tbl[19] = mk(I_IDLE,  C_RUN,   4'b0111, 1'b0, 16'd5, 16'd1);
    tbl[20] = mk(I_HR,    C_DRAIN, 4'b1111, 1'b0, 16'd5, 16'd1);
    tbl[21] = mk(I_HR,    C_DRAIN, 4'b1110, 1'b0, 16'd5, 16'd1);
    tbl[22] = mk(I_HR,    C_DRAIN, 4'b1100, 1'b0, 16'd5, 16'd1);
    tbl[23] = mk(I_HR,    C_DRAIN, 4'b1000, 1'b0, 16'd5, 16'd1);
    tbl[24] = mk(I_HR,    C_HALT,  4'b0000, 1'b1, 16'd5, 16'd1);
    tbl[25] = mk(I_IDLE,  C_HALT,  4'b0000, 1'b1, 16'd5, 16'd1);
    tbl[26] = mk(I_IDLE,  C_RUN,   4'b0000, 1'b0, 16'd5, 16'd1);
    tbl[27] = mk(I_IDLE,  C_RUN,   4'b0001, 1'b0, 16'd5, 16'd1);
    tbl[28] = mk(I_IDLE,  C_RUN,   4'b0011, 1'b0, 16'd5, 16'd1);
    tbl[29] = mk(I_MW,    C_WAIT,  4'b0111, 1'b0, 16'd5, 16'd1);
    tbl[30] = mk(I_RSTMW, C_RST,   4'b0111, 1'b0, 16'd6, 16'd1);
    tbl[31] = mk(I_MW,    C_RUN,   4'b0000, 1'b0, 16'd0, 16'd0);

    {hazard_stall, branch_taken, mem_req, mem_ready, halt_req, reset} = I_RST;
    @(posedge clk);
    #1;
    tick(I_RST, a_ctl, a_vld, a_halt, a_sc, a_fc);
    tick(I_RST, a_ctl, a_vld, a_halt, a_sc, a_fc);
    chk_en = 1'b1;

    for (int r = 0; r < 32; r++) begin
      tick(tbl[r].in, a_ctl, a_vld, a_halt, a_sc, a_fc);
      chk($sformatf("tbl%0d_ctl", r), 32'(a_ctl), 32'(tbl[r].ctl));
      chk($sformatf("tbl%0d_vld", r), 32'(a_vld), 32'(tbl[r].vld));
      chk($sformatf("tbl%0d_halted", r), 32'(a_halt), 32'(tbl[r].halt));
      chk($sformatf("tbl%0d_stall_cycles", r), 32'(a_sc), PERF ? 32'(tbl[r].sc) : 32'd0);
      chk($sformatf("tbl%0d_flush_count", r), 32'(a_fc), PERF ? 32'(tbl[r].fc) : 32'd0);
    end

    // Randomized traffic with a slowly toggling halt level.
    hr_lvl = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(19) == 0) hr_lvl = ~hr_lvl;
      iv[5] = ($urandom_range(3) == 0);
      iv[4] = ($urandom_range(6) == 0);
      iv[3] = 1'($urandom_range(1));
      iv[2] = ($urandom_range(9) < 6);
      iv[1] = hr_lvl;
      iv[0] = ($urandom_range(149) == 0);
      tick(iv, a_ctl, a_vld, a_halt, a_sc, a_fc);
    end

    // Stall counter saturation.
    tick(I_RST, a_ctl, a_vld, a_halt, a_sc, a_fc);
    for (int c = 0; c < 4; c++) tick(I_IDLE, a_ctl, a_vld, a_halt, a_sc, a_fc);
    for (int c = 0; c < 65540; c++) tick(I_HZ, a_ctl, a_vld, a_halt, a_sc, a_fc);
    tick(I_IDLE, a_ctl, a_vld, a_halt, a_sc, a_fc);
    chk("stall_saturate", 32'(a_sc), PERF ? 32'h0000_FFFF : 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
